// File: rtl/rscl_types.sv
// Shared types for the scalar register file / load scoreboard slice.
package rscl_types;
    typedef logic [31:0] word_t;
    typedef logic [4:0]  rnum_t;

    localparam int RSCL_LQ_DEPTH_DEFAULT = 4;
    // Extra top bit separates full from empty when the low bits match.
    typedef logic [$clog2(RSCL_LQ_DEPTH_DEFAULT):0] lq_ptr_t;
endpackage

// File: rtl/rscl_fifo.sv
// Small in-order FIFO used as the outstanding-load queue; the caller never
// pushes into a full queue without popping in the same cycle.
module rscl_fifo #(
    parameter int W     = 5,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0][W-1:0] mem;
    logic [AW:0]             wr_ptr, rd_ptr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
            if (pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
        end
    end
endmodule

// File: rtl/rscl_rf_sb.sv
// Register file with load scoreboard: pending bits, in-order load queue, exec stall.
// Define RSCL_RF_LOAD_BYPASS_EN to forward load-return data to same-cycle readers.
module rscl_rf_sb import rscl_types::*; #(
    parameter int NREAD    = 2,
    parameter int NREG     = 32,
    parameter int LQ_DEPTH = RSCL_LQ_DEPTH_DEFAULT,
    localparam int RW      = $clog2(NREG)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       d_d_valid,
    output logic                       d_d_ready,
    input  logic                       d_d_err,
    input  word_t                      d_d_data,
    input  logic [NREAD-1:0]           rd_en,
    input  logic [NREAD-1:0][RW-1:0]   rd_addr,
    output word_t [NREAD-1:0]          rd_data,
    input  logic                       wr_valid,
    input  logic                       wr_load,
    input  logic [RW-1:0]              wr_rd,
    input  word_t                      wr_data,
    output logic                       exec_stall,
    output logic                       lq_empty,
    output logic                       load_fault,
    output logic [RW-1:0]              load_fault_rd
);
    word_t [NREG-1:0]  rf;
    logic [NREG-1:0]   pending;
    logic [RW-1:0]     lq_head;
    logic              lq_full, lq_empty_i;
    logic              hs, ld_ok, push;
    logic [NREAD-1:0]  rd_block;

    assign lq_empty  = lq_empty_i;
    assign d_d_ready = !lq_empty_i;
    assign hs        = d_d_valid && d_d_ready;
    assign ld_ok     = hs && !d_d_err;

    for (genvar g = 0; g < NREAD; g++) begin : g_rd
`ifdef RSCL_RF_LOAD_BYPASS_EN
        logic fwd;
        assign fwd         = ld_ok && rd_en[g] && (rd_addr[g] == lq_head) && (lq_head != '0);
        assign rd_block[g] = rd_en[g] && (rd_addr[g] != '0) && pending[rd_addr[g]] && !fwd;
        assign rd_data[g]  = (rd_addr[g] == '0) ? '0 : (fwd ? d_d_data : rf[rd_addr[g]]);
`else
        assign rd_block[g] = rd_en[g] && (rd_addr[g] != '0) && pending[rd_addr[g]];
        assign rd_data[g]  = (rd_addr[g] == '0) ? '0 : rf[rd_addr[g]];
`endif
    end

    // A pop frees a slot in the same cycle, so a full queue only stalls without one.
    assign exec_stall = (|rd_block)
                      || (wr_valid && pending[wr_rd])
                      || (wr_valid && wr_load && lq_full && !hs);
    assign push = wr_valid && wr_load && !exec_stall;

    rscl_fifo #(.W(RW), .DEPTH(LQ_DEPTH)) u_lq (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (wr_rd),
        .pop   (hs),
        .dout  (lq_head),
        .full  (lq_full),
        .empty (lq_empty_i)
    );

    // WAW stall guarantees exec and load-return writes never target the same register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf            <= '0;
            pending       <= '0;
            load_fault    <= 1'b0;
            load_fault_rd <= '0;
        end else begin
            if (wr_valid && !wr_load && !exec_stall && (wr_rd != '0)) rf[wr_rd] <= wr_data;
            if (ld_ok && (lq_head != '0)) rf[lq_head] <= d_d_data;
            if (hs) pending[lq_head] <= 1'b0;
            if (push && (wr_rd != '0)) pending[wr_rd] <= 1'b1;
            load_fault    <= hs && d_d_err;
            load_fault_rd <= (hs && d_d_err) ? lq_head : '0;
        end
    end
endmodule
